// File: rtl/l1a_header_fifo_if.sv
// l1a_header_fifo_if: L1A-maker, readout-sequencer and BX-timing signals of the header FIFO
interface l1a_header_fifo_if #(
    parameter int AW = 4
);
    logic          bc0;
    logic [11:0]   bxn_offset;
    logic          l1a_outp;
    logic [11:0]   l1a_in_count;
    logic          raw_we_en;
    logic [3:0]    best_wnd;
    logic [4:0]    raw_wnd;
    logic          rd_en;
    logic [33:0]   hdr_dout;
    logic          hdr_valid;
    logic          l1a_fifo_full;
    logic [AW:0]   hdr_count;
    logic          ovf;
    logic [7:0]    drop_count;
    logic [11:0]   bxn;

    modport master (
        output bc0, bxn_offset, l1a_outp, l1a_in_count, raw_we_en, best_wnd, raw_wnd, rd_en,
        input  hdr_dout, hdr_valid, l1a_fifo_full, hdr_count, ovf, drop_count, bxn
    );

    modport slave (
        input  bc0, bxn_offset, l1a_outp, l1a_in_count, raw_we_en, best_wnd, raw_wnd, rd_en,
        output hdr_dout, hdr_valid, l1a_fifo_full, hdr_count, ovf, drop_count, bxn
    );
endinterface

// File: rtl/l1a_header_fifo.sv
// l1a_header_fifo: per-L1A header FIFO with bunch-crossing counter and overflow accounting
module l1a_header_fifo #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int BX_MAX       = 3563,
    parameter int AFULL_MARGIN = 1
) (
    input logic              clk,
    input logic              reset,
    l1a_header_fifo_if.slave bus
);
    localparam logic [AW:0] full_lvl  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] afull_lvl = (AW + 1)'(DEPTH - AFULL_MARGIN);
    localparam logic [11:0] bx_last   = 12'(BX_MAX);

    logic [33:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count, count_nxt;
    logic          push, pop, drop, afull, ovf_r;
    logic [7:0]    drop_r;
    logic [11:0]   bx;

    assign push = bus.l1a_outp && count != full_lvl;
    assign drop = bus.l1a_outp && count == full_lvl;
    assign pop  = bus.rd_en && count != '0;

    // Next occupancy; a pop at full frees a slot only for the following cycle
    always_comb count_nxt = (push && !pop) ? count + 1'b1 : ((pop && !push) ? count - 1'b1 : count);

    // Bunch-crossing counter: reload on bc0, otherwise wrap after the last BX (oversized offsets wrap next)
    always_ff @(posedge clk or negedge reset)
        if (!reset) bx <= '0;
        else bx <= bus.bc0 ? bus.bxn_offset : (bx >= bx_last ? 12'd0 : bx + 12'd1);

    // Header storage; entries carry the pre-update BX value and are never reset
    always_ff @(posedge clk)
        if (push) mem[wp] <= {bus.l1a_in_count, bx, bus.raw_we_en, bus.best_wnd, bus.raw_wnd};

    // Pointers, occupancy and registered almost-full
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            afull <= 1'b0;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop);
            count <= count_nxt;
            afull <= count_nxt >= afull_lvl;
        end

    // Sticky overflow flag and saturating count of L1As lost to a full FIFO
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            ovf_r  <= 1'b0;
            drop_r <= '0;
        end else if (drop) begin
            ovf_r  <= 1'b1;
            drop_r <= drop_r + 8'(drop_r != 8'hff);
        end

    assign bus.hdr_dout      = mem[rp];
    assign bus.hdr_valid     = count != '0;
    assign bus.l1a_fifo_full = afull;
    assign bus.hdr_count     = count;
    assign bus.ovf           = ovf_r;
    assign bus.drop_count    = drop_r;
    assign bus.bxn           = bx;
endmodule

// File: tb/tb_l1a_header_fifo.sv
// tb_l1a_header_fifo: directed and random stimulus checked against a queue-based header FIFO model
module tb_l1a_header_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    l1a_header_fifo_if #(.AW(AW)) bus();

    l1a_header_fifo #(
        .DEPTH(DEPTH),
        .AW(AW),
        .BX_MAX(3563),
        .AFULL_MARGIN(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [33:0] q[$];
    int          m_bx   = 0;
    int          m_drop = 0;
    bit          m_ovf  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        bus.bc0          = 1'b0;
        bus.bxn_offset   = '0;
        bus.l1a_outp     = 1'b0;
        bus.l1a_in_count = '0;
        bus.raw_we_en    = 1'b0;
        bus.best_wnd     = '0;
        bus.raw_wnd      = '0;
        bus.rd_en        = 1'b0;
    endtask

    task automatic rand_data();
        bus.l1a_in_count = 12'($urandom);
        bus.raw_we_en    = 1'($urandom);
        bus.best_wnd     = 4'($urandom);
        bus.raw_wnd      = 5'($urandom);
    endtask

    task automatic model_edge();
        int n;
        bit do_push;
        n       = q.size();
        do_push = bus.l1a_outp && n < DEPTH;
        if (bus.l1a_outp && n == DEPTH) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end
        if (bus.rd_en && n > 0) void'(q.pop_front());
        if (do_push) q.push_back({bus.l1a_in_count, 12'(m_bx), bus.raw_we_en, bus.best_wnd, bus.raw_wnd});
        m_bx = bus.bc0 ? int'(bus.bxn_offset) : (m_bx >= 3563 ? 0 : m_bx + 1);
    endtask

    task automatic check_all();
        check("valid", 64'(bus.hdr_valid), 64'(q.size() != 0));
        check("count", 64'(bus.hdr_count), 64'(q.size()));
        check("afull", 64'(bus.l1a_fifo_full), 64'(q.size() >= DEPTH - 1));
        check("ovf", 64'(bus.ovf), 64'(m_ovf));
        check("drops", 64'(bus.drop_count), 64'(m_drop));
        check("bxn", 64'(bus.bxn), 64'(m_bx));
        if (q.size() != 0) check("dout", 64'(bus.hdr_dout), 64'(q[0]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic push_one(input logic [11:0] n, input bit rd);
        rand_data();
        bus.l1a_in_count = n;
        bus.l1a_outp     = 1'b1;
        bus.rd_en        = rd;
        step();
        idle();
    endtask

    task automatic drain();
        bus.rd_en = 1'b1;
        for (int g = 0; g < 100 && q.size() != 0; g++) step();
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        bus.bc0        = 1'b1;
        bus.bxn_offset = 12'd5;
        step();
        idle();
        check("t1_bx_load", 64'(bus.bxn), 64'd5);
        for (int i = 0; i < 20 && m_bx != 10; i++) step();
        bus.l1a_outp     = 1'b1;
        bus.l1a_in_count = 12'h123;
        bus.raw_we_en    = 1'b1;
        bus.best_wnd     = 4'd7;
        bus.raw_wnd      = 5'd12;
        step();
        idle();
        check("t1_dout", 64'(bus.hdr_dout), 64'({12'h123, 12'd10, 1'b1, 4'd7, 5'd12}));
        check("t1_count", 64'(bus.hdr_count), 64'd1);
        check("t1_valid", 64'(bus.hdr_valid), 64'd1);
        drain();

        bus.bc0        = 1'b1;
        bus.bxn_offset = 12'd3560;
        step();
        idle();
        for (int i = 0; i < 10 && m_bx != 3563; i++) step();
        push_one(12'h2a, 1'b0);
        check("t2_bx_field", 64'(bus.hdr_dout[21:10]), 64'd3563);
        check("t2_wrap", 64'(bus.bxn), 64'd0);
        repeat (3570) step();
        drain();
        bus.bc0        = 1'b1;
        bus.bxn_offset = 12'd4000;
        step();
        idle();
        step();
        check("t2_oversize_wrap", 64'(bus.bxn), 64'd0);

        for (int i = 0; i < 15; i++) push_one(12'(i), 1'b0);
        check("t3_afull", 64'(bus.l1a_fifo_full), 64'd1);
        push_one(12'd15, 1'b0);
        check("t3_count16", 64'(bus.hdr_count), 64'd16);
        check("t3_no_ovf", 64'(bus.ovf), 64'd0);
        push_one(12'd16, 1'b0);
        check("t3_ovf", 64'(bus.ovf), 64'd1);
        check("t3_drop", 64'(bus.drop_count), 64'd1);
        check("t3_count_hold", 64'(bus.hdr_count), 64'd16);
        for (int i = 0; i < 16; i++) begin
            check("t3_order", 64'(bus.hdr_dout[33:22]), 64'(i));
            bus.rd_en = 1'b1;
            step();
            idle();
        end
        check("t3_empty", 64'(bus.hdr_valid), 64'd0);

        for (int i = 0; i < 16; i++) push_one(12'(100 + i), 1'b0);
        push_one(12'd999, 1'b1);
        check("t4_full_pp_count", 64'(bus.hdr_count), 64'd15);
        check("t4_full_pp_drop", 64'(bus.drop_count), 64'd2);
        check("t4_full_pp_head", 64'(bus.hdr_dout[33:22]), 64'd101);
        push_one(12'd7, 1'b0);
        repeat (260) push_one(12'd7, 1'b0);
        check("t4_drop_sat", 64'(bus.drop_count), 64'd255);
        drain();
        push_one(12'd5, 1'b1);
        check("t4_empty_pp_count", 64'(bus.hdr_count), 64'd1);
        check("t4_empty_pp_valid", 64'(bus.hdr_valid), 64'd1);
        drain();

        repeat (3) push_one(12'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) push_one(12'($urandom), 1'b1);
        check("t5_steady", 64'(bus.hdr_count), 64'd3);
        drain();

        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 1000; i++) begin
                rand_data();
                bus.l1a_outp   = $urandom_range(0, 99) < 70 - 20 * p;
                bus.rd_en      = $urandom_range(0, 99) < 30 + 20 * p;
                bus.bc0        = $urandom_range(0, 99) < 2;
                bus.bxn_offset = 12'($urandom);
                step();
                idle();
            end
        end
        drain();

        for (int i = 0; i < 9; i++) push_one(12'($urandom), 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("t6_valid", 64'(bus.hdr_valid), 64'd0);
        check("t6_afull", 64'(bus.l1a_fifo_full), 64'd0);
        check("t6_count", 64'(bus.hdr_count), 64'd0);
        check("t6_ovf", 64'(bus.ovf), 64'd0);
        check("t6_drop", 64'(bus.drop_count), 64'd0);
        check("t6_bxn", 64'(bus.bxn), 64'd0);
        q.delete();
        m_bx   = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
        #2;
        reset = 1'b1;
        push_one(12'h3c, 1'b0);
        push_one(12'h3d, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/l1a_header_fifo.md
Name: l1a_header_fifo

Overview:
- Sits directly downstream of the L1A maker and consumes its accepted-L1A strobe (l1a_outp), the L1A number (l1a_in_count) and the window settings.
- Per accepted L1A, stores one header entry in a FIFO: L1A number, bunch-crossing number, raw-enable flag, best/raw window lengths.
- The entry is read later by the DAQ readout sequencer.
- Returns l1a_fifo_full to the maker, which gates further L1As with it.
- Contains the bunch-crossing counter used to time-stamp entries.

Parameters:
DEPTH, 16, number of header entries; power of 2, range 4..64
AW, 4, address width = log2(DEPTH)
BX_MAX, 3563, last bunch-crossing value before wrap to 0
AFULL_MARGIN, 1, l1a_fifo_full asserts when count >= DEPTH - AFULL_MARGIN

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
bc0  in  1  bunch-crossing-zero strobe, 1 cycle
bxn_offset  in  12  value loaded into BX counter on bc0
l1a_outp  in  1  accepted L1A strobe from L1A maker (push request)
l1a_in_count  in  12  L1A number from L1A maker
raw_we_en  in  1  raw readout enabled for this L1A
best_wnd  in  4  best-track window length
raw_wnd  in  5  raw-hit window length
rd_en  in  1  pop request from readout sequencer
hdr_dout  out  34  {l1a_num[33:22], bxn[21:10], raw_flag[9], best_wnd[8:5], raw_wnd[4:0]}
hdr_valid  out  1  FIFO not empty; hdr_dout is valid (show-ahead)
l1a_fifo_full  out  1  almost-full, to L1A maker
hdr_count  out  AW+1  current occupancy
ovf  out  1  sticky: push attempted at count == DEPTH
drop_count  out  8  pushes lost to true-full, saturating at 255
bxn  out  12  current bunch-crossing number

Behaviour:
- Reset (reset=0, asynchronous):
  - count, read and write pointers = 0; hdr_valid = 0; l1a_fifo_full = 0; ovf = 0; drop_count = 0; bxn = 0.
  - Storage contents are don't-care.
- A reset assertion mid-operation discards all stored entries immediately.
- BX counter:
  - bc0 = 1: bxn <= bxn_offset. Offsets above BX_MAX are loaded as-is and wrap to 0 on the next increment.
  - Otherwise: bxn <= (bxn >= BX_MAX) ? 0 : bxn + 1.
- Push:
  - push = l1a_outp && (count < DEPTH).
  - The entry captures l1a_in_count, the bxn register value in that same cycle (pre-update), raw_we_en, best_wnd and raw_wnd.
  - Write pointer increments modulo DEPTH.
- Pop:
  - pop = rd_en && (count != 0).
  - Read pointer increments modulo DEPTH.
  - hdr_dout shows the head entry combinationally from storage, or registered with zero added latency: a written entry is visible at hdr_dout one cycle after the push edge.
- Simultaneous events:
  - Push and pop in the same cycle with 0 < count < DEPTH: both occur, count unchanged.
  - Push and pop at count == 0: push occurs, pop ignored, count becomes 1.
  - Push and pop at count == DEPTH: pop occurs; push is rejected and counted as a drop, because full is evaluated from the registered count.
- Overflow:
  - l1a_outp at count == DEPTH sets ovf (cleared only by reset) and increments drop_count, which saturates at 255.
  - Stored data is not modified.
- Flags:
  - hdr_valid = (count != 0).
  - l1a_fifo_full = (count >= DEPTH - AFULL_MARGIN); registered, updated on the same edge as count.
  - hdr_count = count.
- rd_en while empty has no effect on any state.
- Pointer wrap: the pointers are AW bits and wrap naturally. Occupancy is tracked by the separate AW+1-bit count and is never derived from the pointer difference.

Test Plan:
1. Release reset, bc0 with bxn_offset=5; pulse l1a_outp at bxn=10 with l1a_in_count=0x123, raw_we_en=1, best_wnd=7, raw_wnd=12 -> next cycle hdr_valid=1, hdr_dout={0x123, 10, 1, 7, 12}, hdr_count=1.
2. No bc0 for 3570 cycles from bxn=3560 -> bxn sequence 3561, 3562, 3563, 0, 1; header pushed at bxn=3563 stores 3563.
3. DEPTH=16, AFULL_MARGIN=1: 15 pushes -> l1a_fifo_full=1; 16th push -> count=16; 17th push -> ovf=1, drop_count=1, count stays 16; pop 16 entries -> order preserved, l1a_in_count 0..15.
4. At count=16, assert l1a_outp and rd_en together -> count=15, drop_count increments, ovf=1; at count=0, assert both together -> count=1, hdr_valid=1.
5. Steady state at count=3 with push+pop every cycle for 40 cycles (pointer wraps) -> count stays 3, entries emerge in FIFO order.
6. Assert reset asynchronously mid-burst at count=9 -> hdr_valid, l1a_fifo_full, hdr_count, ovf and drop_count go to 0 without waiting for a clock edge.
